rr_arbiter_4port: RTL and testbench

RR_ARBITER_4PORT -- requirements
Module: rr_arbiter_4port

---
 rtl/noc_rr_pkg.sv | 7 +
 rtl/rr_arbiter_4port_if.sv | 10 +
 rtl/rr_arbiter_4port_pick.sv | 21 ++
 rtl/rr_arbiter_4port.sv | 49 ++++
 tb/tb_rr_arbiter_4port.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/noc_rr_pkg.sv
// noc_rr_pkg: shared constants and FSM state type for the 4-port round-robin arbiter
package noc_rr_pkg;
  localparam int NUM_PORTS = 4;
  localparam logic [NUM_PORTS-1:0] RR_RESET_PRIORITY = 4'b0100;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} rr_state_e;
endpackage

// File: rtl/rr_arbiter_4port_if.sv
// rr_arbiter_4port_if: request/grant handshake between input ports and the arbiter
interface rr_arbiter_4port_if;
  import noc_rr_pkg::*;
  logic [NUM_PORTS-1:0] req_i, tail_i, priority_order_i, grant_o;
  logic ready_i, fire_o, change_order_o, timeout_o;
  modport master(output req_i, tail_i, ready_i, priority_order_i,
                 input grant_o, fire_o, change_order_o, timeout_o);
  modport slave(input req_i, tail_i, ready_i, priority_order_i,
                output grant_o, fire_o, change_order_o, timeout_o);
endinterface

// File: rtl/rr_arbiter_4port_pick.sv
// rr_priority_pick: first requesting port in rank order starting at the one-hot priority bit
module rr_priority_pick
  import noc_rr_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] prio,
  output logic [NUM_PORTS-1:0] pick
);
  logic [1:0] base;
  logic [1:0] idx;
  always_comb begin
    base = '0;
    for (int i = 0; i < NUM_PORTS; i++) if ($onehot(prio) && prio[i]) base = 2'(i);
    pick = '0;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = base + 2'(i);
      if (pick == '0 && req[idx]) pick[idx] = 1'b1;
    end
  end
endmodule

// File: rtl/rr_arbiter_4port.sv
// rr_arbiter_4port: packet-locked round-robin arbiter over 4 ports.
// Define RR_ARB_TIMEOUT_EN to add a watchdog that releases grants stalled TIMEOUT_CYCLES cycles.
module rr_arbiter_4port
  import noc_rr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic clk,
  input logic reset,
  rr_arbiter_4port_if.slave bus
);
  localparam logic [0:0] IDLE = 1'(ST_IDLE);
  localparam logic [0:0] LOCKED = 1'(ST_LOCKED);
  logic [0:0] state;
  logic [NUM_PORTS-1:0] grant, pick;
  logic locked, fire, change, timeout;
  rr_priority_pick u_pick (.req(bus.req_i), .prio(bus.priority_order_i), .pick(pick));
  assign locked = state == LOCKED;
  assign fire = locked && bus.ready_i && |(grant & bus.req_i);
  assign change = (fire && |(grant & bus.tail_i)) || timeout;
`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] stall;
  assign timeout = locked && !fire && stall == CW'(TIMEOUT_CYCLES - 1);
  // Held at zero in IDLE, so every new grant starts counting from zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) stall <= '0;
    else stall <= (!locked || fire) ? '0 : stall + 1'b1;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
    end else if (change) begin
      state <= IDLE;
      grant <= '0;
    end else if (!locked && bus.req_i != '0) begin
      state <= LOCKED;
      grant <= pick;
    end
  assign bus.grant_o = grant;
  assign bus.fire_o = fire;
  assign bus.change_order_o = change;
  assign bus.timeout_o = timeout;
endmodule

// File: tb/tb_rr_arbiter_4port.sv
// tb_rr_arbiter_4port: directed scenarios plus randomized traffic against a packet-level model
module tb_rr_arbiter_4port;
  import noc_rr_pkg::*;
  localparam int T = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  bit m_locked = 1'b0;
  int m_g = 0;
  int m_stall = 0;
  rr_arbiter_4port_if bus ();
  rr_arbiter_4port #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  function automatic int rank_pick(logic [3:0] req, logic [3:0] prio);
    int k = 0;
    if ($countones(prio) == 1) for (int i = 0; i < 4; i++) if (prio[i]) k = i;
    for (int i = 0; i < 4; i++) if (req[(k + i) % 4]) return (k + i) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] e_grant();
    return m_locked ? 4'(1 << m_g) : 4'b0000;
  endfunction

  function automatic logic e_fire();
    return m_locked && bus.ready_i && bus.req_i[m_g];
  endfunction

  function automatic logic e_to();
`ifdef RR_ARB_TIMEOUT_EN
    return m_locked && !e_fire() && m_stall == T - 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic e_co();
    return (e_fire() && bus.tail_i[m_g]) || e_to();
  endfunction

  task automatic set(logic [3:0] req, logic [3:0] tail, logic ready, logic [3:0] prio);
    bus.req_i = req;
    bus.tail_i = tail;
    bus.ready_i = ready;
    bus.priority_order_i = prio;
  endtask

  // Advance one clock, updating the packet-level model from the inputs seen this cycle
  task automatic cycle();
    bit f, co;
    f = e_fire();
    co = e_co();
    @(posedge clk);
    if (!reset) begin
      m_locked = 1'b0;
      m_stall = 0;
    end else if (co) m_locked = 1'b0;
    else if (!m_locked) begin
      if (bus.req_i != 4'b0000) begin
        m_locked = 1'b1;
        m_g = rank_pick(bus.req_i, bus.priority_order_i);
        m_stall = 0;
      end
    end else m_stall = f ? 0 : m_stall + 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    set(4'b1111, 4'b1111, 1'b1, RR_RESET_PRIORITY);
    #1;
    checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", bus.grant_o); end
    checks++; if (bus.fire_o !== 1'b0) begin errors++; $display("FAIL reset_fire got %b want 0", bus.fire_o); end
    checks++; if (bus.change_order_o !== 1'b0) begin errors++; $display("FAIL reset_change got %b want 0", bus.change_order_o); end
    checks++; if (bus.timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", bus.timeout_o); end
    cycle();
    #1;
    checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL reset_held_grant got %b want 0000", bus.grant_o); end
    reset = 1'b1;
    set(4'b0000, 4'b0000, 1'b0, RR_RESET_PRIORITY);
    cycle();
  endtask

  task automatic test_packet();
    set(4'b1011, 4'b0000, 1'b0, 4'b0100);
    #1;
    checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL idle_grant got %b want 0000", bus.grant_o); end
    cycle();
    for (int f = 1; f <= 3; f++) begin
      set(4'b1011, f == 3 ? 4'b1000 : 4'b0000, 1'b1, 4'b0100);
      #1;
      checks++; if (bus.grant_o !== 4'b1000) begin errors++; $display("FAIL pkt_grant flit %0d got %b want 1000", f, bus.grant_o); end
      checks++; if (bus.fire_o !== 1'b1) begin errors++; $display("FAIL pkt_fire flit %0d got %b want 1", f, bus.fire_o); end
      checks++; if (bus.change_order_o !== (f == 3)) begin errors++; $display("FAIL pkt_change flit %0d got %b want %b", f, bus.change_order_o, f == 3); end
      cycle();
    end
    set(4'b1011, 4'b0000, 1'b1, 4'b1000);
    #1;
    checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL pkt_bubble_grant got %b want 0000", bus.grant_o); end
    checks++; if (bus.change_order_o !== 1'b0) begin errors++; $display("FAIL pkt_bubble_change got %b want 0", bus.change_order_o); end
    cycle();
    #1;
    checks++; if (bus.grant_o !== 4'b1000) begin errors++; $display("FAIL pkt_rotated_grant got %b want 1000", bus.grant_o); end
    set(4'b1000, 4'b1000, 1'b1, 4'b1000);
    cycle();
    set(4'b0000, 4'b0000, 1'b0, 4'b0001);
    cycle();
  endtask

  task automatic test_stall();
    set(4'b0001, 4'b0000, 1'b0, 4'b0001);
    cycle();
    for (int c = 0; c < 5; c++) begin
      set(4'($urandom) | 4'b1110, 4'($urandom), 1'b0, 4'(1 << (c % 4)));
      #1;
      checks++; if (bus.grant_o !== 4'b0001) begin errors++; $display("FAIL stall_grant cycle %0d got %b want 0001", c, bus.grant_o); end
      checks++; if (bus.fire_o !== 1'b0) begin errors++; $display("FAIL stall_fire cycle %0d got %b want 0", c, bus.fire_o); end
      checks++; if (bus.change_order_o !== 1'b0) begin errors++; $display("FAIL stall_change cycle %0d got %b want 0", c, bus.change_order_o); end
      cycle();
    end
    set(4'b0001, 4'b0001, 1'b1, 4'b0001);
    #1;
    checks++; if (bus.change_order_o !== 1'b1) begin errors++; $display("FAIL stall_release got %b want 1", bus.change_order_o); end
    cycle();
  endtask

  task automatic test_invalid_priority();
    set(4'b0110, 4'b0000, 1'b0, 4'b0110);
    cycle();
    #1;
    checks++; if (bus.grant_o !== 4'b0010) begin errors++; $display("FAIL invalid_prio_grant got %b want 0010", bus.grant_o); end
    set(4'b0010, 4'b0010, 1'b1, 4'b0000);
    cycle();
    set(4'b1001, 4'b0000, 1'b0, 4'b0000);
    cycle();
    #1;
    checks++; if (bus.grant_o !== 4'b0001) begin errors++; $display("FAIL zero_prio_grant got %b want 0001", bus.grant_o); end
    set(4'b0001, 4'b0001, 1'b1, 4'b0001);
    cycle();
  endtask

  task automatic test_reset_mid();
    set(4'b0100, 4'b0000, 1'b0, 4'b0100);
    cycle();
    set(4'b0100, 4'b0000, 1'b1, 4'b0100);
    #1;
    checks++; if (bus.grant_o !== 4'b0100) begin errors++; $display("FAIL mid_grant got %b want 0100", bus.grant_o); end
    cycle();
    set(4'b0100, 4'b0100, 1'b1, 4'b0100);
    #1;
    reset = 1'b0;
    #1;
    checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL mid_reset_grant got %b want 0000", bus.grant_o); end
    checks++; if (bus.change_order_o !== 1'b0) begin errors++; $display("FAIL mid_reset_change got %b want 0", bus.change_order_o); end
    checks++; if (bus.fire_o !== 1'b0) begin errors++; $display("FAIL mid_reset_fire got %b want 0", bus.fire_o); end
    cycle();
    #1;
    checks++; if (bus.change_order_o !== 1'b0) begin errors++; $display("FAIL mid_reset_change2 got %b want 0", bus.change_order_o); end
    reset = 1'b1;
    set(4'b0000, 4'b0000, 1'b0, 4'b0100);
    cycle();
  endtask

`ifdef RR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    set(4'b0010, 4'b0000, 1'b0, 4'b0010);
    cycle();
    for (int n = 1; n <= T; n++) begin
      set(4'b0000, 4'b0000, 1'b1, 4'b0010);
      #1;
      checks++; if (bus.timeout_o !== (n == T)) begin errors++; $display("FAIL wd_timeout stall %0d got %b want %b", n, bus.timeout_o, n == T); end
      checks++; if (bus.change_order_o !== (n == T)) begin errors++; $display("FAIL wd_change stall %0d got %b want %b", n, bus.change_order_o, n == T); end
      cycle();
    end
    #1;
    checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL wd_idle_grant got %b want 0000", bus.grant_o); end
  endtask
`else
  task automatic test_hold();
    set(4'b0010, 4'b0000, 1'b0, 4'b0010);
    cycle();
    for (int n = 1; n <= T + 4; n++) begin
      set(4'b0000, 4'b0000, 1'b1, 4'b0001);
      #1;
      if (n == T || n == T + 4) begin
        checks++; if (bus.grant_o !== 4'b0010) begin errors++; $display("FAIL hold_grant stall %0d got %b want 0010", n, bus.grant_o); end
        checks++; if (bus.timeout_o !== 1'b0 || bus.change_order_o !== 1'b0) begin errors++; $display("FAIL hold_release stall %0d got to=%b co=%b want 0 0", n, bus.timeout_o, bus.change_order_o); end
      end
      cycle();
    end
    set(4'b0010, 4'b0010, 1'b1, 4'b0001);
    cycle();
  endtask
`endif

  task automatic test_random();
    logic [3:0] prio;
    reset = 1'b0;
    set(4'b0000, 4'b0000, 1'b0, RR_RESET_PRIORITY);
    cycle();
    reset = 1'b1;
    for (int c = 0; c < 400; c++) begin
      prio = $urandom_range(0, 4) == 0 ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      set($urandom_range(0, 5) == 0 ? 4'b0000 : 4'($urandom), 4'($urandom), $urandom_range(0, 3) != 0, prio);
      #1;
      checks++; if (bus.grant_o !== e_grant()) begin errors++; $display("FAIL rnd_grant cycle %0d got %b want %b", c, bus.grant_o, e_grant()); end
      checks++; if (bus.fire_o !== e_fire()) begin errors++; $display("FAIL rnd_fire cycle %0d got %b want %b", c, bus.fire_o, e_fire()); end
      checks++; if (bus.change_order_o !== e_co()) begin errors++; $display("FAIL rnd_change cycle %0d got %b want %b", c, bus.change_order_o, e_co()); end
      checks++; if (bus.timeout_o !== e_to()) begin errors++; $display("FAIL rnd_timeout cycle %0d got %b want %b", c, bus.timeout_o, e_to()); end
      cycle();
    end
  endtask

  initial begin
    set(4'b0000, 4'b0000, 1'b0, RR_RESET_PRIORITY);
    test_reset();
    test_packet();
    test_stall();
    test_invalid_priority();
    test_reset_mid();
`ifdef RR_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
